// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register and its helpers.
package pipe_pkg;

  // Holding state of a pipeline register slot.
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FULL    = 2'd1,
    ST_SKIDDED = 2'd2
  } state_e;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_CNT_W  = 16;

  // Number of payload entries held in a given state.
  function automatic logic [1:0] occ_of(input state_e s);
    logic [1:0] occ;
    case (s)
      ST_EMPTY:   occ = 2'd0;
      ST_FULL:    occ = 2'd1;
      ST_SKIDDED: occ = 2'd2;
      default:    occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle on both sides of a pipeline register.
// slave: the register itself; master: the surrounding stages.
interface pipe_skid_reg_if #(
  parameter int DATA_W = pipe_pkg::DEF_DATA_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones until reset.
module sat_counter #(
  parameter int W = pipe_pkg::DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;
  logic         w_sat;

  assign w_sat = &r_cnt;
  assign o_cnt = r_cnt;

  // count enabled cycles, hold once every bit is set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_en && !w_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register with optional two-entry skid buffer,
// synchronous flush and a saturating stall-cycle counter.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   ST_EMPTY   | nothing held, accepting, out_valid low
//   ST_FULL    | main register holds the head payload
//   ST_SKIDDED | main holds head, skid holds next (SKID=1 only)
//
// out_data always comes from the main register; the skid entry only
// moves into main when the head is taken downstream.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter bit                SKID      = 1'b1,
  parameter int                CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_skid_reg_if.slave   bus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] w_skid;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_stall;

  assign w_in_fire  = bus.in_valid && w_in_ready;
  assign w_out_fire = w_out_valid && bus.out_ready;
  assign w_stall    = w_out_valid && !bus.out_ready;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state: flush wins over any handshake in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) w_state_nxt = ST_FULL;
        end
        ST_FULL: begin
          // without a skid slot in_ready tracks out_ready, so the
          // accept-without-drain case cannot occur in that mode
          if (w_in_fire && !w_out_fire) begin
            w_state_nxt = SKID ? ST_SKIDDED : ST_FULL;
          end else if (!w_in_fire && w_out_fire) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_SKIDDED: begin
          if (w_out_fire) w_state_nxt = ST_FULL;
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // outputs decoded from state; in_ready stays registered in skid mode
  always_comb begin
    w_out_valid = (r_state != ST_EMPTY);
    occupancy   = occ_of(r_state);
    if (SKID) begin
      w_in_ready = (r_state != ST_SKIDDED);
    end else begin
      w_in_ready = (r_state == ST_EMPTY) || bus.out_ready;
    end
  end

  // main register next value: new payload, promoted skid, or squash
  always_comb begin
    w_main_nxt = r_main;
    if (flush) begin
      w_main_nxt = RESET_VAL;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) w_main_nxt = bus.in_data;
        end
        ST_FULL: begin
          if (w_in_fire && w_out_fire) w_main_nxt = bus.in_data;
        end
        ST_SKIDDED: begin
          if (w_out_fire) w_main_nxt = w_skid;
        end
        default: w_main_nxt = r_main;
      endcase
    end
  end

  // main data register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main <= RESET_VAL;
    end else begin
      r_main <= w_main_nxt;
    end
  end

  generate
    if (SKID) begin : g_skid
      logic [DATA_W-1:0] r_skid;
      logic              w_skid_load;

      // capture a beat that arrived while the head was stalled
      assign w_skid_load = (r_state == ST_FULL) && w_in_fire && !w_out_fire;

      // skid data register
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_skid <= RESET_VAL;
        end else if (flush) begin
          r_skid <= RESET_VAL;
        end else if (w_skid_load) begin
          r_skid <= bus.in_data;
        end
      end

      assign w_skid = r_skid;
    end else begin : g_no_skid
      assign w_skid = RESET_VAL;
    end
  endgenerate

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst),
    .i_en  (w_stall),
    .o_cnt (stall_cnt)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_main;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: a skid-mode instance (16-bit counter) and a
// single-entry instance (4-bit counter) share one stimulus stream; each
// is scored against a FIFO model of its own capacity.
module tb_pipe_skid_reg;
  import pipe_pkg::*;

  localparam int          DW = 16;
  localparam logic [15:0] RV = 16'hA5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic s_valid = 1'b0;
  logic s_ready = 1'b0;
  logic [15:0] s_data = '0;

  always #5 clk = ~clk;

  pipe_skid_reg_if #(.DATA_W(DW)) if_a ();
  pipe_skid_reg_if #(.DATA_W(DW)) if_b ();

  logic [1:0]  occ_a, occ_b;
  logic [15:0] st_a;
  logic [3:0]  st_b;

  assign if_a.in_valid  = s_valid;
  assign if_a.in_data   = s_data;
  assign if_a.out_ready = s_ready;
  assign if_b.in_valid  = s_valid;
  assign if_b.in_data   = s_data;
  assign if_b.out_ready = s_ready;

  pipe_skid_reg #(.DATA_W(DW), .RESET_VAL(RV), .SKID(1'b1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .bus(if_a), .occupancy(occ_a), .stall_cnt(st_a));

  pipe_skid_reg #(.DATA_W(DW), .RESET_VAL(RV), .SKID(1'b0), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .bus(if_b), .occupancy(occ_b), .stall_cnt(st_b));

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // per-instance views so one monitor loop serves both
  logic        v_ov[2];
  logic        v_ir[2];
  logic [15:0] v_od[2];
  logic [1:0]  v_occ[2];
  logic [15:0] v_st[2];

  assign v_ov[0]  = if_a.out_valid;
  assign v_ov[1]  = if_b.out_valid;
  assign v_ir[0]  = if_a.in_ready;
  assign v_ir[1]  = if_b.in_ready;
  assign v_od[0]  = if_a.out_data;
  assign v_od[1]  = if_b.out_data;
  assign v_occ[0] = occ_a;
  assign v_occ[1] = occ_b;
  assign v_st[0]  = st_a;
  assign v_st[1]  = {12'd0, st_b};

  function automatic int cap_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic int sat_max(input int k);
    return (k == 0) ? 65535 : 15;
  endfunction

  // reference model: expected payload queue and stall count per instance
  logic [15:0] q[2][$];
  int          m_st[2];
  bit          pend_push[2];
  logic [15:0] pend_d[2];
  bit          pend_clr;

  // output monitor: checks status against the model and pops on delivery
  always @(negedge clk) begin
    pend_clr = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bit e_ir;
      pend_push[k] = 1'b0;
      if (!rst) begin
        q[k].delete();
        m_st[k] = 0;
        chk($sformatf("rst_out_valid[%0d]", k), 32'(v_ov[k]), 32'(0));
        chk($sformatf("rst_in_ready[%0d]", k), 32'(v_ir[k]), 32'(1));
        chk($sformatf("rst_occupancy[%0d]", k), 32'(v_occ[k]), 32'(0));
        chk($sformatf("rst_out_data[%0d]", k), 32'(v_od[k]), 32'(RV));
        chk($sformatf("rst_stall[%0d]", k), 32'(v_st[k]), 32'(0));
      end else begin
        if (cap_of(k) == 2) e_ir = (q[k].size() < 2);
        else                e_ir = (q[k].size() == 0) || s_ready;
        chk($sformatf("out_valid[%0d]", k), 32'(v_ov[k]), 32'(q[k].size() > 0));
        chk($sformatf("in_ready[%0d]", k), 32'(v_ir[k]), 32'(e_ir));
        chk($sformatf("occupancy[%0d]", k), 32'(v_occ[k]), 32'(q[k].size()));
        chk($sformatf("stall_cnt[%0d]", k), 32'(v_st[k]), 32'(m_st[k]));
        if (v_ov[k] && !s_ready && m_st[k] < sat_max(k)) m_st[k]++;
        if (v_ov[k] && s_ready) begin
          if (q[k].size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_out[%0d] actual=%0h required=no_output at %0t", k, v_od[k], $time);
          end else begin
            chk($sformatf("out_data[%0d]", k), 32'(v_od[k]), 32'(q[k].pop_front()));
          end
        end
        if (flush) begin
          pend_clr = 1'b1;
        end else if (s_valid && v_ir[k]) begin
          pend_push[k] = 1'b1;
          pend_d[k]    = s_data;
        end
      end
    end
  end

  // input side: accepted payloads become expected outputs at the edge
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (pend_clr) q[k].delete();
      else if (pend_push[k]) q[k].push_back(pend_d[k]);
    end
  end

  task automatic drive(input logic v, input logic [15:0] d, input logic r, input logic f);
    s_valid = v;
    s_data  = d;
    s_ready = r;
    flush   = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    s_valid = 1'b1;
    s_data  = 16'd125;
    s_ready = 1'b0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(if_a.out_valid), 32'(0));
    chk("reset_out_data", 32'(if_a.out_data), 32'(RV));
    chk("reset_in_ready", 32'(if_a.in_ready), 32'(1));
    chk("reset_occupancy", 32'(occ_a), 32'(0));
    s_valid = 1'b0;
    rst = 1'b1;
    drive(1'b0, 16'd0, 1'b1, 1'b0);

    // streaming with downstream always ready
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 16'(i), 1'b1, 1'b0);
      chk("stream_valid", 32'(if_a.out_valid), 32'(1));
      chk("stream_data", 32'(if_a.out_data), 32'(i));
    end
    drive(1'b0, 16'd0, 1'b1, 1'b0);
    chk("stream_drained", 32'(if_a.out_valid), 32'(0));
    chk("stream_stall", 32'(st_a), 32'(0));

    // backpressure fills the skid slot
    drive(1'b1, 16'd10, 1'b0, 1'b0);
    chk("bp_occ1", 32'(occ_a), 32'(1));
    chk("bp_ready_after_10", 32'(if_a.in_ready), 32'(1));
    drive(1'b1, 16'd11, 1'b0, 1'b0);
    chk("bp_occ2", 32'(occ_a), 32'(2));
    chk("bp_ready_after_11", 32'(if_a.in_ready), 32'(0));
    drive(1'b1, 16'd12, 1'b0, 1'b0);
    drive(1'b1, 16'd12, 1'b0, 1'b0);
    chk("bp_hold_occ", 32'(occ_a), 32'(2));
    chk("bp_stall", 32'(st_a), 32'(3));
    drive(1'b1, 16'd12, 1'b1, 1'b0);
    chk("bp_second", 32'(if_a.out_data), 32'(11));
    drive(1'b1, 16'd12, 1'b1, 1'b0);
    chk("bp_third", 32'(if_a.out_data), 32'(12));
    drive(1'b0, 16'd0, 1'b1, 1'b0);
    chk("bp_drained", 32'(if_a.out_valid), 32'(0));
    chk("bp_stall_final", 32'(st_a), 32'(3));

    // flush with both slots full and a simultaneous accept
    drive(1'b1, 16'd20, 1'b0, 1'b0);
    drive(1'b1, 16'd21, 1'b0, 1'b0);
    chk("fl_occ_before", 32'(occ_a), 32'(2));
    drive(1'b1, 16'd22, 1'b0, 1'b1);
    chk("fl_occ", 32'(occ_a), 32'(0));
    chk("fl_valid", 32'(if_a.out_valid), 32'(0));
    chk("fl_data", 32'(if_a.out_data), 32'(RV));
    chk("fl_data_b", 32'(if_b.out_data), 32'(RV));
    chk("fl_stall_kept", 32'(st_a), 32'(5));
    repeat (2) begin
      drive(1'b0, 16'd0, 1'b1, 1'b0);
      chk("fl_no_22", 32'(if_a.out_valid), 32'(0));
    end

    // long stall: 4-bit counter on the single-entry instance saturates
    repeat (20) drive(1'b1, 16'd30, 1'b0, 1'b0);
    chk("sat_b", 32'(st_b), 32'(15));
    drive(1'b1, 16'd30, 1'b0, 1'b0);
    chk("sat_b_hold", 32'(st_b), 32'(15));

    // single-entry mode: in_ready follows out_ready in the same cycle
    chk("s0_held_data", 32'(if_b.out_data), 32'(30));
    chk("s0_ready_low", 32'(if_b.in_ready), 32'(0));
    s_valid = 1'b1;
    s_data  = 16'd31;
    s_ready = 1'b1;
    #1;
    chk("s0_ready_comb", 32'(if_b.in_ready), 32'(1));
    @(posedge clk);
    #1;
    chk("s0_no_gap_valid", 32'(if_b.out_valid), 32'(1));
    chk("s0_no_gap_data", 32'(if_b.out_data), 32'(31));
    repeat (3) drive(1'b0, 16'd0, 1'b1, 1'b0);

    // randomized traffic with occasional flush
    repeat (600) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 31) == 0));
    end

    // reset in the middle of a transfer drops everything at once
    drive(1'b1, 16'd40, 1'b0, 1'b0);
    drive(1'b1, 16'd41, 1'b0, 1'b0);
    s_valid = 1'b0;
    rst = 1'b0;
    #2;
    chk("mid_rst_valid", 32'(if_a.out_valid), 32'(0));
    chk("mid_rst_occ", 32'(occ_a), 32'(0));
    chk("mid_rst_data", 32'(if_a.out_data), 32'(RV));
    chk("mid_rst_ready", 32'(if_a.in_ready), 32'(1));
    chk("mid_rst_valid_b", 32'(if_b.out_valid), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) begin
      drive(1'b0, 16'd0, 1'b1, 1'b0);
      chk("post_rst_idle", 32'(if_a.out_valid), 32'(0));
    end
    chk("post_rst_stall", 32'(st_a), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised elastic pipeline register, the successor to the plain N-bit write-enabled register used between datapath stages. It carries a DATA_W-bit payload between two pipeline stages over a valid/ready handshake and adds a two-entry skid buffer so upstream `in_ready` is registered. It also provides a synchronous flush for branch/exception squashing and a saturating stall-cycle counter for performance observation. It sits between each pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- `DATA_W`, 32, payload width in bits (≥1).
- `RESET_VAL`, 0, value loaded into all data registers on reset and flush.
- `SKID`, 1, 1 = two-entry skid mode (full throughput, registered `in_ready`); 0 = single-entry mode (`in_ready` combinational from `out_ready`).
- `CNT_W`, 16, stall counter width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous squash of all held entries.
- `in_valid`  in  1  upstream payload valid.
- `in_ready`  out  1  this block can accept.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  payload available downstream.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  DATA_W  payload to downstream, always driven from the main register.
- `occupancy`  out  2  entries held (0..2).
- `stall_cnt`  out  CNT_W  cycles with `out_valid && !out_ready`, saturating.

## Operation
- Transfers:
  - In-fire = `in_valid && in_ready`.
  - Out-fire = `out_valid && out_ready`.
  - All state updates on the rising `clk` edge.
- States: EMPTY (occupancy 0), FULL (main valid, occupancy 1), SKIDDED (main and skid valid, occupancy 2; SKID=1 only).
- EMPTY:
  - `in_ready`=1, `out_valid`=0.
  - In-fire → FULL, main←`in_data`.
- FULL:
  - `out_valid`=1.
  - `in_ready`=1 if SKID=1; `in_ready`=`out_ready` if SKID=0.
  - In+out fire → FULL, main←`in_data`.
  - Out only → EMPTY.
  - In only → SKIDDED, skid←`in_data`.
- SKIDDED:
  - `in_ready`=0, `out_valid`=1.
  - Out-fire → FULL, main←skid.
- Ordering: strict FIFO; no payload is duplicated or dropped except by flush.
- Flush:
  - Highest priority. Next state is EMPTY; main and skid ← RESET_VAL.
  - An in-fire in the flush cycle is discarded.
  - An out-fire in the flush cycle is a valid delivery, because the downstream observed it.
- stall_cnt:
  - Increments each cycle `out_valid && !out_ready`.
  - Holds at 2^CNT_W−1.
  - Cleared only by reset; unaffected by flush.
- `occupancy`, `out_valid` and `in_ready` (SKID=1) are pure decodes of the state register.

## Timing
- Reset (`rst`=0, asynchronous): state EMPTY, `out_valid`=0, `out_data`=RESET_VAL, `in_ready`=1, `occupancy`=0, `stall_cnt`=0. Release is synchronous to the next `clk` edge.
- Latency: in-fire at edge N makes `out_valid`=1 and `out_data` valid after edge N (visible in cycle N+1).
- Throughput: one transfer per cycle with `out_ready` held high, in both modes.
- SKID=1: `in_ready` has no combinational path from `out_ready` or `flush`. It drops one cycle after the stall that filled the skid.
- SKID=0: combinational `out_ready`→`in_ready` path is permitted.
- Reset mid-transfer: all held entries are lost immediately; no partial output.

## Structure
- Shared package `pipe_pkg`: state encoding (EMPTY=2'd0, FULL=2'd1, SKIDDED=2'd2) and the default widths (data 32, counter 16).
- One sub-module: `sat_counter` (parametrised width, async active-low reset, enable, saturating increment), reused by other performance counters.
- Skid logic is generated only when SKID=1; SKID=0 elaborates with no skid register.

## Test plan
- Reset: hold `rst`=0 with `in_valid`=1 and `in_data`=125. Required: `out_valid`=0, `out_data`=RESET_VAL, `in_ready`=1, `occupancy`=0 throughout.
- Streaming (SKID=1, `out_ready`=1): send 1,2,3,4 on consecutive cycles. Required: `out_data` shows 1,2,3,4 one cycle later, no bubbles, `stall_cnt`=0.
- Backpressure:
  - Setup: `out_ready`=0 while sending 10 then 11.
  - Required: `occupancy`=2; `in_ready`=0 the cycle after 11 is accepted; 12 is held upstream.
  - Then raise `out_ready`. Required: 10, 11, 12 emerge in order; `stall_cnt` equals the number of stalled cycles.
- Flush: with occupancy 2 (values 20, 21), assert `flush` together with in-fire of 22. Required: next cycle `occupancy`=0, `out_valid`=0, `out_data`=RESET_VAL, and 22 never appears.
- Saturation (CNT_W=4): stall 20 cycles. Required: `stall_cnt` stops at 15 and holds.
- SKID=0: `out_ready`=0 with 30 held. Required: `in_ready`=0 in the same cycle; raising `out_ready` and `in_valid` together passes 31 with no gap.
